// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: control-word bit map, sequencer states and opcodes.
// Imported by the sequencer, the control unit and the datapath.
package cpu_pkg;

  localparam int CW_W = 13;

  localparam int CW_A_LD   = 12;
  localparam int CW_A_OE   = 11;
  localparam int CW_ALU_OE = 10;
  localparam int CW_B_LD   = 9;
  localparam int CW_B_OE   = 8;
  localparam int CW_RSVD   = 7;
  localparam int CW_O_LD   = 6;
  localparam int CW_PC_INC = 5;
  localparam int CW_PC_LD  = 4;
  localparam int CW_MEM_OE = 3;
  localparam int CW_IR_LD  = 2;
  localparam int CW_IC_EN  = 1;
  localparam int CW_IC_CLR = 0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_OUT = 8'h0E;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_HLT = 8'h0F;

endpackage

// File: rtl/instr_sequencer_step_counter.sv
// Micro-step counter: clear beats enable, and an enable at the maximum count
// holds the value and raises ovf instead of wrapping.
module step_counter #(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [STEP_W-1:0] step,
  output logic              ovf
);

  logic [STEP_W-1:0] step_d, step_q;

  always_comb begin
    ovf    = en && !clr && (step_q == {STEP_W{1'b1}});
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (en && !ovf) begin
      step_d = step_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/instr_sequencer.sv
// Consumer of the control word: owns PC, IR and the step counter, runs the
// program-memory read handshake and stalls execution until memory answers.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW_W-1:0]   cw,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        instr,
  output logic [STEP_W-1:0] step,
  output logic              cw_exec,
  output logic              fault
);

  seq_state_e        state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [7:0]        ir_d, ir_q;
  logic              fault_d, fault_q;
  logic              step_clr, step_en, step_ovf;
  logic              unused_cw;

  // Upper CW bits belong to the datapath only.
  assign unused_cw = ^cw[CW_W-1:6];

  step_counter #(.STEP_W(STEP_W)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (step_clr),
    .en    (step_en),
    .step  (step),
    .ovf   (step_ovf)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    fault_d  = fault_q;
    mem_req  = 1'b0;
    cw_exec  = 1'b0;
    step_clr = 1'b0;
    step_en  = 1'b0;

    unique case (state_q)
      BOOT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d     = mem_rdata;
          pc_d     = '0;
          step_clr = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        mem_req = cw[CW_MEM_OE];
        cw_exec = !cw[CW_MEM_OE] || mem_ack;
        if (cw_exec) begin
          step_clr = cw[CW_IC_CLR];
          step_en  = cw[CW_IC_EN];
          // Without MEM_OE the read bus is not ours, so a PC load sees zero.
          if (cw[CW_PC_LD]) begin
            pc_d = cw[CW_MEM_OE] ? ADDR_W'(mem_rdata) : '0;
          end else if (cw[CW_PC_INC]) begin
            pc_d = pc_q + ADDR_W'(1);
          end
          if (cw[CW_IR_LD] && cw[CW_MEM_OE]) begin
            ir_d = mem_rdata;
          end
          if (step_ovf) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
      end
      default: state_d = HALT;
    endcase

    if (!rst_n) begin
      mem_req  = 1'b0;
      cw_exec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= '0;
      ir_q    <= 8'h00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  assign mem_addr = pc_q;
  assign instr    = ir_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer, checked against a
// behavioural model of the sequencing rules kept in the bench.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic [12:0] cw;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  instr;
  logic [2:0]  step;
  logic        cw_exec;
  logic        fault;

  int vectors;
  int miscompares;

  // Reference model: plain numbers and a mode code.
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  int m_mode;
  int m_pc;
  int m_ir;
  int m_step;
  int m_fault;

  instr_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cw        (cw),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .instr     (instr),
    .step      (step),
    .cw_exec   (cw_exec),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock period: drive on the negedge, check combinational outputs,
  // advance the model, then check registered state just after the posedge.
  task automatic applyStimulus(input logic [12:0] c, input logic a, input logic [7:0] d, input logic r);
    int exp_req;
    int exp_exec;
    @(negedge clk);
    cw = c; mem_ack = a; mem_rdata = d; rst_n = r;
    #1;
    exp_req  = 0;
    exp_exec = 0;
    if (r) begin
      if (m_mode == M_BOOT) exp_req = 1;
      if (m_mode == M_RUN) begin
        exp_req  = c[3] ? 1 : 0;
        exp_exec = (!c[3] || a) ? 1 : 0;
      end
    end
    checkOutput("mem_req", 16'(mem_req), 16'(exp_req));
    checkOutput("cw_exec", 16'(cw_exec), 16'(exp_exec));
    checkOutput("mem_addr", 16'(mem_addr), 16'(m_pc));

    if (!r) begin
      m_mode = M_BOOT; m_pc = 0; m_ir = 0; m_step = 0; m_fault = 0;
    end else if (m_mode == M_BOOT) begin
      if (a) begin
        m_ir = d; m_pc = 0; m_step = 0; m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN && exp_exec == 1) begin
      if (c[4])      m_pc = c[3] ? d : 0;
      else if (c[5]) m_pc = (m_pc + 1) % 256;
      if (c[2] && c[3]) m_ir = d;
      if (c[0]) m_step = 0;
      else if (c[1]) begin
        if (m_step == 7) begin
          m_mode = M_HALT; m_fault = 1;
        end else begin
          m_step = m_step + 1;
        end
      end
    end

    @(posedge clk);
    #1;
    checkOutput("instr", 16'(instr), 16'(m_ir));
    checkOutput("step", 16'(step), 16'(m_step));
    checkOutput("fault", 16'(fault), 16'(m_fault));
    checkOutput("pc", 16'(mem_addr), 16'(m_pc));
  endtask

  initial begin
    logic [12:0] rc;
    logic        ra;
    vectors = 0; miscompares = 0;
    m_mode = M_BOOT; m_pc = 0; m_ir = 0; m_step = 0; m_fault = 0;
    cw = '0; mem_ack = 1'b0; mem_rdata = 8'h00; rst_n = 1'b0;

    $display("[TB] reset and boot");
    applyStimulus(13'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(13'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(13'h0, 1'b0, 8'h77, 1'b1);
    applyStimulus(13'h0, 1'b0, 8'h66, 1'b1);
    applyStimulus(13'h0, 1'b1, 8'h05, 1'b1);

    $display("[TB] nop fetch");
    applyStimulus(13'b0000000100010, 1'b0, 8'h00, 1'b1);
    applyStimulus(13'b0000000001111, 1'b1, 8'h02, 1'b1);

    $display("[TB] jump");
    applyStimulus(13'b0000000111010, 1'b1, 8'h40, 1'b1);

    $display("[TB] stall");
    applyStimulus(13'b0000000001110, 1'b0, 8'hAA, 1'b1);
    applyStimulus(13'b0000000001110, 1'b0, 8'hBB, 1'b1);
    applyStimulus(13'b0000000001110, 1'b0, 8'hCC, 1'b1);
    applyStimulus(13'b0000000001110, 1'b1, 8'h99, 1'b1);
    applyStimulus(13'b0000000000001, 1'b0, 8'h00, 1'b1);

    $display("[TB] step overflow");
    for (int i = 0; i < 8; i++) applyStimulus(13'b0000000000010, 1'b0, 8'h00, 1'b1);
    applyStimulus(13'b0000000111111, 1'b1, 8'h3C, 1'b1);
    applyStimulus(13'b0000000000001, 1'b1, 8'h12, 1'b1);

    $display("[TB] reset during stall");
    applyStimulus(13'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(13'h0, 1'b1, 8'h11, 1'b1);
    applyStimulus(13'b0000000100000, 1'b0, 8'h00, 1'b1);
    applyStimulus(13'b0000000001100, 1'b0, 8'h00, 1'b1);
    applyStimulus(13'b0000000001100, 1'b1, 8'hE7, 1'b0);
    applyStimulus(13'b0000000000000, 1'b0, 8'h00, 1'b1);

    $display("[TB] random control words");
    for (int i = 0; i < 400; i++) begin
      rc = 13'($urandom);
      ra = ($urandom_range(0, 2) == 0);
      if (m_mode == M_HALT && $urandom_range(0, 3) == 0)
        applyStimulus(rc, ra, 8'($urandom), 1'b0);
      else if ($urandom_range(0, 39) == 0)
        applyStimulus(rc, ra, 8'($urandom), 1'b0);
      else
        applyStimulus(rc, ra, 8'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
